// File: rtl/dev_io_arbiter.sv
// Two-client ownership arbiter for the shared I/O channel: req/gnt handshake,
// round-robin on ties, and a drain + guard gap before select may move.
module dev_io_arbiter #(
  parameter bit INIT_SELECT   = 1'b0,
  parameter int GUARD_CYCLES  = 2,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic select,
  input  logic putc_push,
  input  logic putc_push_done,
  input  logic getc_pop,
  output logic busy,
  output logic drain_err
);

  localparam int MAX_CNT = (GUARD_CYCLES > DRAIN_TIMEOUT) ? GUARD_CYCLES : DRAIN_TIMEOUT;
  localparam int CW      = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] GUARD_LIM = CW'(GUARD_CYCLES);
  localparam logic [CW-1:0] TOUT_LIM  = CW'(DRAIN_TIMEOUT);
  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_reg;
  logic          gnt0_reg;
  logic          gnt1_reg;
  logic          select_reg;
  logic          busy_reg;
  logic          drain_err_reg;
  logic          last_owner_reg;
  logic          pending_reg;
  logic [CW-1:0] guard_cnt_reg;
  logic [CW-1:0] tout_cnt_reg;

  logic          quiet;
  logic          owner_req;
  logic          pick;
  logic          timeout_hit;
  logic [CW-1:0] tout_inc;

  always_comb begin
    quiet       = !pending_reg && !putc_push && !getc_pop;
    owner_req   = select_reg ? req1 : req0;
    // On a tie the side that did not own the channel last wins.
    pick        = (req0 && req1) ? ~last_owner_reg : req1;
    tout_inc    = (tout_cnt_reg == CNT_SAT) ? tout_cnt_reg : tout_cnt_reg + CNT_ONE;
    timeout_hit = (DRAIN_TIMEOUT != 0) && (state_reg == DRAIN) && !quiet &&
                  (tout_inc == TOUT_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      gnt0_reg       <= 1'b0;
      gnt1_reg       <= 1'b0;
      select_reg     <= INIT_SELECT;
      busy_reg       <= 1'b0;
      drain_err_reg  <= 1'b0;
      last_owner_reg <= ~INIT_SELECT;
      pending_reg    <= 1'b0;
      guard_cnt_reg  <= '0;
      tout_cnt_reg   <= '0;
    end else begin
      // A timed-out drain abandons the outstanding putc so the guard can run.
      if (timeout_hit || putc_push_done) begin
        pending_reg <= 1'b0;
      end else if (putc_push) begin
        pending_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (req0 || req1) begin
            select_reg     <= pick;
            gnt0_reg       <= ~pick;
            gnt1_reg       <= pick;
            last_owner_reg <= pick;
            busy_reg       <= 1'b1;
            state_reg      <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            gnt0_reg      <= 1'b0;
            gnt1_reg      <= 1'b0;
            guard_cnt_reg <= '0;
            tout_cnt_reg  <= '0;
            state_reg     <= DRAIN;
          end
        end
        DRAIN: begin
          if (guard_cnt_reg == GUARD_LIM) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
          if (!quiet) begin
            guard_cnt_reg <= '0;
            tout_cnt_reg  <= tout_inc;
          end else if (guard_cnt_reg != CNT_SAT) begin
            guard_cnt_reg <= guard_cnt_reg + CNT_ONE;
          end
          if (timeout_hit) begin
            drain_err_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign gnt0      = gnt0_reg;
  assign gnt1      = gnt1_reg;
  assign select    = select_reg;
  assign busy      = busy_reg;
  assign drain_err = drain_err_reg;

endmodule

// File: tb/tb_dev_io_arbiter.sv
// Bench for dev_io_arbiter: two instances (long and short drain timeout) share
// stimulus; a cycle model is checked every cycle plus literal handover timings.
module tb_dev_io_arbiter;

  localparam int GUARD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic putc_push = 1'b0;
  logic putc_push_done = 1'b0;
  logic getc_pop = 1'b0;
  logic [1:0] g0, g1, sel, bsy, err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dev_io_arbiter #(.INIT_SELECT(1'b0), .GUARD_CYCLES(GUARD), .DRAIN_TIMEOUT(1024)) dut_a (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .gnt0(g0[0]), .gnt1(g1[0]), .select(sel[0]),
    .putc_push(putc_push), .putc_push_done(putc_push_done), .getc_pop(getc_pop),
    .busy(bsy[0]), .drain_err(err[0])
  );

  dev_io_arbiter #(.INIT_SELECT(1'b0), .GUARD_CYCLES(GUARD), .DRAIN_TIMEOUT(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .gnt0(g0[1]), .gnt1(g1[1]), .select(sel[1]),
    .putc_push(putc_push), .putc_push_done(putc_push_done), .getc_pop(getc_pop),
    .busy(bsy[1]), .drain_err(err[1])
  );

  // Model: phase 0 = free, 1 = owned, 2 = draining. qrun counts consecutive
  // quiet draining cycles, nrun counts noisy draining cycles.
  int m_phase[2];
  int m_owner[2];
  int m_last[2];
  int m_sel[2];
  int m_pend[2];
  int m_qrun[2];
  int m_nrun[2];
  int m_err[2];
  int m_tout[2] = '{1024, 8};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_owner[i] = 0; m_last[i] = 1; m_sel[i] = 0;
      m_pend[i] = 0; m_qrun[i] = 0; m_nrun[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit quiet;
      bit forced;
      bit leave;
      int w;
      quiet  = (m_pend[i] == 0) && !putc_push && !getc_pop;
      forced = 1'b0;
      if (m_phase[i] == 0) begin
        if (req0 || req1) begin
          w = (req0 && req1) ? 1 - m_last[i] : (req1 ? 1 : 0);
          m_owner[i] = w; m_sel[i] = w; m_last[i] = w; m_phase[i] = 1;
        end
      end else if (m_phase[i] == 1) begin
        if ((m_owner[i] == 0 && !req0) || (m_owner[i] == 1 && !req1)) begin
          m_phase[i] = 2; m_qrun[i] = 0; m_nrun[i] = 0;
        end
      end else begin
        leave = (m_qrun[i] == GUARD);
        if (quiet) m_qrun[i]++;
        else begin
          m_qrun[i] = 0;
          m_nrun[i]++;
          if (m_nrun[i] == m_tout[i]) begin
            m_err[i] = 1; forced = 1'b1;
          end
        end
        if (leave) m_phase[i] = 0;
      end
      if (forced || putc_push_done) m_pend[i] = 0;
      else if (putc_push) m_pend[i] = 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
          logic [4:0] want;
          logic [4:0] got;
          want = {(m_phase[i] == 1 && m_owner[i] == 0), (m_phase[i] == 1 && m_owner[i] == 1),
                  m_sel[i][0], (m_phase[i] != 0), m_err[i][0]};
          got  = {g0[i], g1[i], sel[i], bsy[i], err[i]};
          total++;
          if (got !== want) begin
            bad++;
            $display("FAIL model_cmp inst=%0d t=%0t got gnt0,gnt1,sel,busy,err=%b want=%b",
                     i, $time, got, want);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    putc_push = 1'b0; putc_push_done = 1'b0; getc_pop = 1'b0;
    tick();
    tick();
    check("reset_outputs", {g0, g1, sel, bsy, err}, 32'd0);
    rst_n = 1'b1;
  endtask

  // Called right after the owner's req is dropped; counts edges after the
  // grant falls (edge e0) until each instance raises gnt1.
  task automatic handover(input int done_at, input int pop_at, output int ea,
                          output int eb, output int eerr, output bit sel_moved);
    int n;
    bit da;
    bit db;
    ea = -1; eb = -1; eerr = -1; sel_moved = 1'b0; da = 1'b0; db = 1'b0; n = 0;
    while (!(da && db) && n < 1200) begin
      tick();
      n++;
      putc_push_done = (n == done_at);
      getc_pop = (n == pop_at);
      if (!da && g1[0]) begin
        da = 1'b1; ea = n - 1;
      end else if (!da && sel[0]) begin
        sel_moved = 1'b1;
      end
      if (!db && g1[1]) begin
        db = 1'b1; eb = n - 1;
      end
      if (eerr < 0 && err[1]) eerr = n - 1;
    end
    putc_push_done = 1'b0;
    getc_pop = 1'b0;
    if (!(da && db)) begin
      total++; bad++;
      $display("FAIL handover_bound got da=%0d db=%0d want both 1", da, db);
    end
  endtask

  int ea, eb, eerr, w;
  bit moved;
  int exp_seq[4] = '{0, 1, 0, 1};

  initial begin
    // Reset then single request from port 1.
    do_reset();
    req1 = 1'b1;
    tick();
    check("single_gnt1", g1[0], 1);
    check("single_sel", sel[0], 1);
    check("single_gnt0", g0[0], 0);
    check("single_busy", bsy[0], 1);

    // Tie after reset goes to port 0; quiet handover takes GUARD+2 edges.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    check("tie_first_gnt0", {g0[0], g1[0]}, 2'b10);
    req0 = 1'b0;
    handover(-1, -1, ea, eb, eerr, moved);
    check("quiet_handover_a", ea, 4);
    check("quiet_handover_b", eb, 4);

    // A getc_pop mid-guard restarts the guard count.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    req0 = 1'b0;
    handover(-1, 2, ea, eb, eerr, moved);
    check("pop_handover_a", ea, 6);

    // In-flight putc completed 10 cycles after release.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    putc_push = 1'b1;
    tick();
    putc_push = 1'b0;
    req0 = 1'b0;
    handover(10, -1, ea, eb, eerr, moved);
    check("putc_handover_a", ea, 14);
    check("putc_sel_held_a", moved, 0);
    check("putc_no_err_a", err[0], 0);
    check("putc_timeout_b", eerr, 8);
    check("putc_handover_b", eb, 12);

    // putc_push_done never arrives: both instances eventually time out.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    putc_push = 1'b1;
    tick();
    putc_push = 1'b0;
    req0 = 1'b0;
    handover(-1, -1, ea, eb, eerr, moved);
    check("timeout_err_edge_b", eerr, 8);
    check("timeout_handover_b", eb, 12);
    check("timeout_handover_a", ea, 1028);
    repeat (5) tick();
    check("timeout_err_sticky", err, 2'b11);

    // Round-robin with both requests held; each owner blips req after its grant.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!(g0[0] || g1[0]) && w < 20) begin
        tick();
        w++;
      end
      check("rr_grant_seq", g1[0] ? 1 : (g0[0] ? 0 : 9), exp_seq[k]);
      if (g1[0]) req1 = 1'b0;
      else req0 = 1'b0;
      tick();
      req0 = 1'b1; req1 = 1'b1;
    end

    // Asynchronous reset while draining with select = 1.
    do_reset();
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    tick();
    check("drain_state", {g1[0], sel[0], bsy[0]}, 3'b011);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {g0, g1, sel, bsy, err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dev_io_arbiter.md
# dev_io_arbiter

Arbitration controller for the two-client I/O switch: decides which of two requesters (port 0 = loader, port 1 = CPU) owns the shared `if_io` channel and drives the switch's `select` input. It grants ownership via a req/gnt handshake and monitors the shared channel so `select` never changes while a `putc` is in flight or a `getc_pop` is active. It then enforces a guard gap before handing the channel to the other side. It sits beside `dev_io_switch`, between the two I/O clients and the UART-side server.

## Interface
- `INIT_SELECT`, 0: reset value of `select`; also wins the first tie after reset.
- `GUARD_CYCLES`, 2: quiet cycles required after release before a new grant.
- `DRAIN_TIMEOUT`, 1024: max cycles to wait for an in-flight `putc` before forcing release; 0 disables the timeout.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0`, `req1`  in  1 each  ownership requests, level; held high for the whole ownership.
- `gnt0`, `gnt1`  out  1 each  grants, registered, one-hot or zero.
- `select`  out  1  to the switch's `select`; 0 = port 0 is routed.
- `putc_push`  in  1  monitored from the shared side of the switch.
- `putc_push_done`  in  1  monitored from the shared side.
- `getc_pop`  in  1  monitored from the shared side.
- `busy`  out  1  high in GRANT and DRAIN.
- `drain_err`  out  1  sticky; set when a drain times out.

## Operation
- **Reset values:**
  - State IDLE.
  - `gnt0` = `gnt1` = 0, `busy` = 0, `drain_err` = 0.
  - `select` = `INIT_SELECT`.
  - `last_owner` = ~`INIT_SELECT`; pending = 0; both counters = 0.
- **Pending flag:**
  - Set on `putc_push & !putc_push_done`.
  - Cleared on `putc_push_done`.
  - Done wins if both are seen in the same cycle.
  - Quiet = `!pending & !putc_push & !getc_pop`.
- **IDLE:**
  - Both requests high: grant the side ≠ `last_owner` (round-robin).
  - Exactly one request high: grant that side.
  - On grant: next edge loads `select`, raises the matching `gnt`, records `last_owner`, and moves to GRANT.
- **GRANT:**
  - Holds while the owner's req is high; the other req is ignored.
  - Owner req low: next edge drops `gnt` and moves to DRAIN.
  - Guard counter and timeout counter clear on entry to DRAIN.
- **DRAIN** (`select` unchanged, both gnt low):
  - Not quiet: guard counter → 0; timeout counter increments.
  - Quiet: guard counter increments.
  - Leave to IDLE on the edge where the guard counter == `GUARD_CYCLES`, compared before increment.
  - If `DRAIN_TIMEOUT` ≠ 0 and the timeout counter reaches `DRAIN_TIMEOUT`: set `drain_err`, force pending = 0, continue guard counting.
- Re-raising req during DRAIN does not abort the drain; the request is arbitrated in IDLE.
- `select` changes only on the IDLE→GRANT edge; it holds the last owner's value through DRAIN and IDLE.
- Counter width: $clog2(max(`GUARD_CYCLES`, `DRAIN_TIMEOUT`) + 1); no wrap, counters saturate.

## Timing
- Request to grant in IDLE: req high before edge e → `gnt` and `select` valid after edge e (1 cycle).
- Release: req low before edge e → `gnt` low after edge e.
- Handover with no traffic: gnt(other) rises `GUARD_CYCLES` + 2 edges after gnt(owner) falls.
- Pending `putc`: handover is extended by the cycles until `putc_push_done`, plus the full guard.
- Asynchronous reset mid-GRANT or mid-DRAIN: all outputs immediately take their reset values.
- `drain_err` clears only on reset.

## Test plan
- **Reset then single request:** reset, `req1`=1 → `gnt1`=1 and `select`=1 one edge later; `gnt0`=0; `busy`=1.
- **Simultaneous requests after reset, `INIT_SELECT`=0:**
  - `req0`=`req1`=1 → `gnt0` first.
  - Drop `req0` → `gnt1` rises exactly 4 edges after `gnt0` falls (`GUARD_CYCLES`=2).
- **In-flight putc:**
  - Owner 0 pushes a putc, then drops `req0` before `putc_push_done`.
  - `putc_push_done` arrives 10 cycles later.
  - Required: `select` stays 0 throughout; `gnt1` rises 10+4 edges after `gnt0` falls.
- **Drain timeout, `DRAIN_TIMEOUT`=8:**
  - `putc_push_done` never arrives.
  - Required: `drain_err`=1 after 8 DRAIN cycles; `gnt1` is granted after the guard; `drain_err` stays sticky.
- **Round-robin:** both reqs held and each owner toggles req after every grant → grants alternate 0,1,0,1; `gnt0` & `gnt1` never both 1.
- **Reset mid-DRAIN:** assert `rst_n`=0 in DRAIN → `gnt` = 0, `select` = `INIT_SELECT`, `busy` = 0 with no clock edge.
